// File: rtl/icache_controller.sv
// icache_controller: direct-mapped instruction cache that stalls the CPU and fills 16-byte lines from instruction memory on a miss.
module icache_controller #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [9:0]   pc_address,
  input  logic         inst_read,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readinst,
  input  logic         mem_busywait,
  output logic [15:0]  miss_count
);
  localparam int INDEX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 6 - INDEX_W;
  localparam int TW = TAG_W > 0 ? TAG_W : 1;
  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;
  state_t state, next_state;
  logic [NUM_BLOCKS-1:0] valid;
  logic [TW-1:0] tags [NUM_BLOCKS];
  logic [127:0] data [NUM_BLOCKS];
  logic [5:0] blk, miss_addr;
  logic [INDEX_W-1:0] idx, miss_idx;
  logic [TW-1:0] pc_tag, miss_tag;
  logic first, hit, miss;
  logic unused_offset_bits;
  assign unused_offset_bits = ^pc_address[1:0];
  assign blk = pc_address[9:4];
  assign idx = blk[INDEX_W-1:0];
  assign pc_tag = TW'(blk >> INDEX_W);
  assign miss_idx = miss_addr[INDEX_W-1:0];
  assign miss_tag = TW'(miss_addr >> INDEX_W);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      first <= 1'b0;
      valid <= '0;
      miss_addr <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      first <= miss;
      if (miss) begin
        miss_addr <= blk;
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
      if (state == UPDATE) valid[miss_idx] <= 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (state == UPDATE) begin
      data[miss_idx] <= mem_readinst;
      tags[miss_idx] <= miss_tag;
    end
  end
  // first suppresses exit on the MEM_READ entry edge, before memory has raised busywait
  always_comb begin
    hit = state == IDLE && inst_read && valid[idx] && tags[idx] == pc_tag;
    miss = state == IDLE && inst_read && !hit;
    next_state = miss ? MEM_READ
               : state == MEM_READ ? (!first && !mem_busywait ? UPDATE : MEM_READ)
               : IDLE;
    mem_read = state == MEM_READ;
    mem_address = mem_read ? miss_addr : 6'd0;
    busywait = reset_n && (miss || state == MEM_READ || state == UPDATE);
    instruction = hit ? data[idx][{pc_address[3:2], 5'b0} +: 32] : 32'd0;
  end
endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
- Direct-mapped instruction cache and controller between the CPU fetch stage and the 1024x8 instruction memory, which returns 16-byte blocks.
- On a hit, it serves 32-bit instructions from cached blocks.
- On a miss, it stalls the CPU via busywait, runs one 128-bit block read from memory, fills the line, then resumes.
- It is the only master of the instruction memory read port.

Parameters:
NUM_BLOCKS, 8, number of cache lines; power of 2, 2..64; INDEX_W = log2(NUM_BLOCKS), TAG_W = 6 - INDEX_W

Ports:
clock  input  1  system clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
pc_address  input  10  CPU byte address: [9:4] block address (tag = upper TAG_W bits, index = lower INDEX_W bits), [3:2] word offset, [1:0] ignored
inst_read  input  1  CPU fetch request, level
instruction  output  32  fetched instruction word
busywait  output  1  CPU stall
mem_read  output  1  instruction memory read request
mem_address  output  6  instruction memory block address
mem_readinst  input  128  block data from memory; byte 0 at [7:0]
mem_busywait  input  1  memory busy; rises with mem_read, falls when mem_readinst is valid
miss_count  output  16  saturating count of misses since reset

Behaviour:
- Storage per line: valid bit, TAG_W-bit tag, 128-bit data.
- Reset (reset_n low, async):
  - all valid bits cleared; FSM to IDLE
  - mem_read=0, mem_address=0, busywait=0, miss_count=0, instruction=0
  - A reset mid-fill abandons the fill; no line is written.
- Hit (combinational, IDLE only): hit = inst_read & valid[index] & (tag[index] == pc tag).
- Word select (combinational): instruction = data[index][32*offset+31 : 32*offset]. It is valid whenever hit=1; on a non-hit the value is don't-care.
- busywait (combinational) = inst_read & ~hit in IDLE; 1 in MEM_READ and UPDATE; 0 otherwise.
- Hit latency: zero cycles; the CPU samples instruction at the same posedge.
- FSM states:
  - IDLE:
    - inst_read & ~hit at posedge -> MEM_READ
    - latch miss_addr = pc_address[9:4]
    - miss_count += 1, saturating at 16'hFFFF
    - otherwise stay in IDLE
  - MEM_READ:
    - mem_read=1, mem_address=miss_addr
    - stay while mem_busywait=1
    - The first posedge in this state never exits: the memory's busywait rises in response to mem_read.
    - at a later posedge with mem_busywait=0 -> UPDATE; mem_read drops at that edge
  - UPDATE, one cycle:
    - at posedge write data[miss index] = mem_readinst, tag = miss tag, valid = 1
    - -> IDLE
    - busywait still 1 during this cycle
- After UPDATE, hit is re-evaluated on the current pc_address. If the CPU changed pc during the stall, a new miss may start immediately.
- mem_read is never asserted outside MEM_READ; there is exactly one read per miss.
- inst_read low in IDLE: no hit, no stall, no state change. inst_read dropping during MEM_READ does not abort the fill.
- Miss penalty with the 40-cycle-per-byte memory is determined by mem_busywait. The controller adds exactly 2 cycles: the MEM_READ entry cycle and UPDATE.
- Conflict misses (same index, different tag) overwrite the line; there is no write-back (read-only cache).

Test Plan:
- Cold miss:
  - stimulus: reset, then inst_read=1, pc=0x000
  - busywait=1 and miss_count=1 after the edge; mem_read=1 with mem_address=0 until mem_busywait falls; one UPDATE cycle
  - then busywait=0 and instruction=0x0004_0019
- Same-block hits: pc=0x004, 0x008, 0x00C after the fill -> instruction=0x0005_0023, 0x0206_0405, 0x0001_005A, each with busywait=0 and no mem_read; miss_count stays 1.
- Next block: pc=0x010 -> miss with mem_address=1, then instruction=0x0301_0104; miss_count=2.
- Conflict (NUM_BLOCKS=8):
  - pc=0x000 then pc=0x080 (same index 0, tag 1) -> second access misses, mem_address=8, line 0 is replaced
  - returning to pc=0x000 misses again; miss_count=3 across these three accesses
- Reset mid-fill:
  - assert reset_n=0 while in MEM_READ -> mem_read=0 and busywait=0 immediately
  - after release, pc=0x000 misses again (no partial line valid); miss_count restarts at 1
- Stall edge cases:
  - hold mem_busywait=1 for 100 cycles -> FSM remains in MEM_READ with mem_read=1 throughout
  - drop inst_read mid-fill -> the fill still completes, and a later same-block fetch hits
